// File: rtl/coll_pkg.sv
// rtl/coll_pkg.sv - shared state encoding and width defaults for the proximity alarm
package coll_pkg;

  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    ALARM  = 2'd2
  } state_t;

endpackage

// File: rtl/coll_abs_cmp.sv
// rtl/coll_abs_cmp.sv - magnitude of a subtractor result and threshold compare
module coll_abs_cmp #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] diff,
  input  logic              borrow,
  input  logic [DATA_W-1:0] thr,
  output logic [DATA_W-1:0] abs_val,
  output logic              near
);

  // A borrow with a zero difference negates to zero, which is the intended magnitude.
  always_comb begin
    abs_val = borrow ? (~diff + DATA_W'(1)) : diff;
    near    = (abs_val <= thr);
  end

endmodule

// File: rtl/coll_proximity_fsm.sv
// rtl/coll_proximity_fsm.sv - registered proximity check with consecutive-hit alarm
// Optional total-hit counter enabled by COLL_HIT_COUNT_EN.
module coll_proximity_fsm
  import coll_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int HIT_N  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_diff,
  input  logic              in_borrow,
  input  logic [DATA_W-1:0] thr,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_abs,
  output logic              out_near,
  output logic              alarm
`ifdef COLL_HIT_COUNT_EN
  ,
  output logic [CNT_W-1:0]  hit_count
`endif
);

  localparam logic [7:0] HIT_MAX = 8'(HIT_N);

  if (HIT_N < 1 || HIT_N > 255) begin : g_bad_hit_n
    $error("HIT_N must be in 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic [DATA_W-1:0] abs_val;
  logic              near;
  logic              accept;
  state_t            state, state_nxt;
  logic [7:0]        run, run_nxt;

  coll_abs_cmp #(.DATA_W(DATA_W)) u_abs_cmp (
    .diff    (in_diff),
    .borrow  (in_borrow),
    .thr     (thr),
    .abs_val (abs_val),
    .near    (near)
  );

  assign in_ready = ~clear & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run   <= 8'd0;
      alarm <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
      alarm <= (state_nxt == ALARM);
    end
  end

  // Run advances only on accepted samples; a single far sample drops back to IDLE.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    if (clear) begin
      state_nxt = IDLE;
      run_nxt   = 8'd0;
    end else if (accept) begin
      if (near) begin
        run_nxt   = (run >= HIT_MAX) ? HIT_MAX : run + 8'd1;
        state_nxt = (run_nxt >= HIT_MAX) ? ALARM : ARMING;
      end else begin
        run_nxt   = 8'd0;
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_abs   <= '0;
      out_near  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_abs   <= abs_val;
      out_near  <= near;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef COLL_HIT_COUNT_EN
  // Lifetime statistic: survives clear, only reset zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (accept && near && (hit_count != {CNT_W{1'b1}})) begin
      hit_count <= hit_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_coll_proximity_fsm.sv
// tb/tb_coll_proximity_fsm.sv - directed self-checking bench for coll_proximity_fsm
module tb_coll_proximity_fsm;

  localparam int DATA_W = 64;
  localparam int HIT_N  = 3;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_diff;
  logic              in_borrow;
  logic [DATA_W-1:0] thr;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_abs;
  logic              out_near;
  logic              alarm;
`ifdef COLL_HIT_COUNT_EN
  logic [CNT_W-1:0]  hit_count;
`endif

  int checks;
  int errors;

  coll_proximity_fsm #(.DATA_W(DATA_W), .HIT_N(HIT_N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_diff   (in_diff),
    .in_borrow (in_borrow),
    .thr       (thr),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_abs   (out_abs),
    .out_near  (out_near),
    .alarm     (alarm)
`ifdef COLL_HIT_COUNT_EN
    ,
    .hit_count (hit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic b);
    in_diff   = d;
    in_borrow = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_diff   = '0;
    in_borrow = 1'b0;
    thr       = 64'd10;
    clear     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_abs", out_abs, 64'd0);
    check("rst_out_near", 64'(out_near), 64'd0);
    check("rst_alarm", 64'(alarm), 64'd0);
`ifdef COLL_HIT_COUNT_EN
    check("rst_hit_count", 64'(hit_count), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // near sample, one-cycle latency
    in_diff = 64'd5; in_borrow = 1'b0; in_valid = 1'b1;
    #1 check("idle_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("near5_valid", 64'(out_valid), 64'd1);
    check("near5_abs", out_abs, 64'd5);
    check("near5_near", 64'(out_near), 64'd1);
    check("near5_alarm", 64'(alarm), 64'd0);

    send(64'd100, 1'b0);
    check("far_near", 64'(out_near), 64'd0);
    check("far_alarm", 64'(alarm), 64'd0);

    // negative difference -7, three in a row raise alarm
    send(64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
    check("neg1_abs", out_abs, 64'd7);
    check("neg1_alarm", 64'(alarm), 64'd0);
    send(64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
    check("neg2_alarm", 64'(alarm), 64'd0);
    send(64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
    check("neg3_alarm", 64'(alarm), 64'd1);
    check("neg3_near", 64'(out_near), 64'd1);
    send(64'd0, 1'b1);
    check("borrow_zero_abs", out_abs, 64'd0);
    check("alarm_hold", 64'(alarm), 64'd1);

    // boundary: abs == thr is near, thr+1 is far and drops the alarm
    send(64'd11, 1'b0);
    check("far11_near", 64'(out_near), 64'd0);
    check("far11_alarm", 64'(alarm), 64'd0);
    send(64'd10, 1'b0);
    check("eq_thr_near", 64'(out_near), 64'd1);
    check("idle_restart_alarm", 64'(alarm), 64'd0);

    // backpressure: result held, input blocked
    send(64'd5, 1'b0);
    out_ready = 1'b0;
    in_diff = 64'd9; in_valid = 1'b1;
    #1 check("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_abs_stable", out_abs, 64'd5);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_alarm", 64'(alarm), 64'd0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_new_abs", out_abs, 64'd9);
    check("bp_new_valid", 64'(out_valid), 64'd1);
    check("bp_run3_alarm", 64'(alarm), 64'd1);

    send(64'd200, 1'b0);
    send(64'd1, 1'b0);
    send(64'd2, 1'b0);
    check("arming_alarm", 64'(alarm), 64'd0);

    // clear with a sample offered while ARMING
    clear = 1'b1;
    in_diff = 64'd3; in_valid = 1'b1;
    #1 check("clr_in_ready", 64'(in_ready), 64'd0);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_out_valid", 64'(out_valid), 64'd0);
    check("clr_alarm", 64'(alarm), 64'd0);
`ifdef COLL_HIT_COUNT_EN
    check("clr_hit_count", 64'(hit_count), 64'd10);
`endif
    send(64'd1, 1'b0);
    check("clr_run1_alarm", 64'(alarm), 64'd0);
    send(64'd1, 1'b0);
    check("clr_run2_alarm", 64'(alarm), 64'd0);
    send(64'd1, 1'b0);
    check("clr_run3_alarm", 64'(alarm), 64'd1);

    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    send(64'd4, 1'b0);
    out_ready = 1'b0;
    tick();

    // asynchronous reset mid-cycle with alarm and a held result
    check("pre_rst_alarm", 64'(alarm), 64'd1);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_abs", out_abs, 64'd0);
    check("arst_near", 64'(out_near), 64'd0);
    check("arst_alarm", 64'(alarm), 64'd0);
`ifdef COLL_HIT_COUNT_EN
    check("arst_hit_count", 64'(hit_count), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(64'd1, 1'b0);
    check("post_rst_alarm", 64'(alarm), 64'd0);
    check("post_rst_valid", 64'(out_valid), 64'd1);

    // 20 near samples total since reset: counter saturates at 15
    for (int i = 2; i <= 20; i++) begin
      send(64'd2, 1'b0);
`ifdef COLL_HIT_COUNT_EN
      if (i == 14) check("hit_count_14", 64'(hit_count), 64'd14);
      if (i == 15) check("hit_count_15", 64'(hit_count), 64'd15);
`endif
    end
`ifdef COLL_HIT_COUNT_EN
    check("hit_count_sat", 64'(hit_count), 64'd15);
`endif
    check("long_run_alarm", 64'(alarm), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
